// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver with scancode prefix decoding and a small key-event FIFO.
// Raw ps2_clk/ps2_data are synchronized, ps2_clk is glitch-filtered, and each
// falling edge of the filtered clock clocks one frame bit into the receive FSM.
// Completed scancodes are merged with pending E0/F0 prefixes and queued.
// Read side: kb_data is a registered view of the head entry; rd_pop is a
// one-cycle strobe that removes the head when the FIFO is not empty.
module ps2_key_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FILTER_LEN     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_pop,
  output logic [15:0]                     kb_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            frame_err,
  output logic [1:0]                      dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // synchronizer / filter state
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_q;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  // receive FSM state
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          byte_vld;
  logic [7:0]    byte_q;

  // decode / FIFO state
  logic          ext_flag, brk_flag;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [15:0]   head_nxt;
  logic [9:0]    push_entry;
  logic          is_prefix, push_req, pop_ok, full, do_push;

  assign dbg_state = state;

  // Two-flop synchronizers; reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: a new ps2_clk level is accepted after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_q <= filt;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // One-cycle strobe on each falling edge of the filtered clock
  assign strobe  = filt_q & ~filt;
  assign timeout = (to_cnt >= TW'(TIMEOUT_CYCLES - 1));

  // Receive FSM: start, 8 data bits LSB first, odd parity, stop; abandons stalled frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
    end else begin
      frame_err <= 1'b0;
      byte_vld  <= 1'b0;
      if (state == S_IDLE || strobe) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (strobe && !dat_s2) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (strobe) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (strobe) begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (strobe) begin
            if (dat_s2 && (^{shreg, par_bit})) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A stalled partial frame is dropped; a strobe in the same cycle wins
      if (state != S_IDLE && !strobe && timeout) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  assign is_prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0);
  assign push_req   = byte_vld && !is_prefix;
  assign pop_ok     = rd_pop && (fifo_count != '0);
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign do_push    = push_req && (!full || pop_ok);
  assign push_entry = {ext_flag, brk_flag, byte_q};

  // Next pointers/count and the head entry as it will look after this edge
  always_comb begin
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = fifo_count;
    head_nxt  = 16'h0000;
    if (do_push) wptr_nxt = wptr + 1'b1;
    if (pop_ok)  rptr_nxt = rptr + 1'b1;
    case ({do_push, pop_ok})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase
    if (count_nxt != '0) begin
      // The new head may be the entry being written this very cycle
      if (do_push && (rptr_nxt == wptr)) head_nxt = {1'b1, 5'b0, push_entry};
      else                               head_nxt = {1'b1, 5'b0, mem[rptr_nxt]};
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_entry;
  end

  // Pointers, count, registered head view, prefix flags and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      kb_data    <= 16'h0000;
      overflow   <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      fifo_count <= count_nxt;
      kb_data    <= head_nxt;
      if (push_req && full && !pop_ok) overflow <= 1'b1;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_vld) begin
        if (byte_q == 8'hE0)      ext_flag <= 1'b1;
        else if (byte_q == 8'hF0) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

endmodule
